// File: rtl/grf_wport_arbiter.sv
// grf_wport_arbiter
//
// Shares the single GRF write port between two sources:
//   - the W-stage writeback (pipe_*)
//   - the multi-cycle MDU result path (mdu_*)
// MDU results are queued in a small circular FIFO. The FIFO drains into the
// GRF on cycles when the W stage does not write. If the FIFO waits MAX_WAIT
// consecutive cycles without a grant, the head is forced through and the
// W stage is stalled. busy_mask lists every register that has a queued write,
// so decode can use it for hazard stalls.
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   pipe_we/a3/wd/pc      W-stage write request (a3 == 0 means no request)
//   pipe_stall            W-stage write not performed this cycle; W must retry
//   mdu_valid/a3/wd/pc    MDU result offer (a3 == 0 is accepted and dropped)
//   mdu_ready             FIFO can accept a result
//   grf_we/a3/wd/pc       GRF write port (all zero when idle)
//   busy_mask             one bit per register with a queued FIFO write

module grf_wport_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_a3,
    input  logic [31:0] pipe_wd,
    input  logic [31:0] pipe_pc,
    output logic        pipe_stall,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_a3,
    input  logic [31:0] mdu_wd,
    input  logic [31:0] mdu_pc,
    output logic        mdu_ready,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc,
    output logic [31:0] busy_mask
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int STV_W = $clog2(MAX_WAIT + 1);

    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [STV_W-1:0] MAX_WAIT_C = STV_W'(MAX_WAIT);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [STV_W-1:0] starve_q, starve_d;

    logic [4:0]  mem_a3_q [DEPTH];
    logic [4:0]  mem_a3_d [DEPTH];
    logic [31:0] mem_wd_q [DEPTH];
    logic [31:0] mem_wd_d [DEPTH];
    logic [31:0] mem_pc_q [DEPTH];
    logic [31:0] mem_pc_d [DEPTH];

    logic pipe_valid;
    logic fifo_nonempty;
    logic force_drain;
    logic grant_fifo;
    logic grant_pipe;
    logic push;
    logic pop;

    // Arbitration. A forced drain beats the pipeline; otherwise the pipeline
    // wins and the FIFO only drains into idle cycles. Holding reset low
    // blocks every grant and every handshake.
    always_comb begin
        pipe_valid    = pipe_we && (pipe_a3 != 5'd0);
        fifo_nonempty = (count_q != '0);
        force_drain   = fifo_nonempty && (starve_q == MAX_WAIT_C);

        grant_fifo = reset && fifo_nonempty && (force_drain || !pipe_valid);
        grant_pipe = reset && pipe_valid && !force_drain;
        pipe_stall = reset && force_drain && pipe_valid;

        // Ready depends only on the current count. A full FIFO refuses a
        // push even when it pops in the same cycle.
        mdu_ready = reset && (count_q < DEPTH_C);
        push      = mdu_valid && mdu_ready && (mdu_a3 != 5'd0);
        pop       = grant_fifo;
    end

    // GRF port mux. It reads registered FIFO state only, so a result pushed
    // at an edge is written no earlier than the next cycle.
    always_comb begin
        grf_we = 1'b0;
        grf_a3 = 5'd0;
        grf_wd = 32'd0;
        grf_pc = 32'd0;
        if (grant_pipe) begin
            grf_we = 1'b1;
            grf_a3 = pipe_a3;
            grf_wd = pipe_wd;
            grf_pc = pipe_pc;
        end else if (grant_fifo) begin
            grf_we = 1'b1;
            grf_a3 = mem_a3_q[rd_ptr_q];
            grf_wd = mem_wd_q[rd_ptr_q];
            grf_pc = mem_pc_q[rd_ptr_q];
        end
    end

    // Next-state logic for pointers, occupancy, storage and the starve
    // counter. Pointers are exactly log2(DEPTH) bits, so they wrap on
    // overflow.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        starve_d = starve_q;
        mem_a3_d = mem_a3_q;
        mem_wd_d = mem_wd_q;
        mem_pc_d = mem_pc_q;

        if (push) begin
            mem_a3_d[wr_ptr_q] = mdu_a3;
            mem_wd_d[wr_ptr_q] = mdu_wd;
            mem_pc_d[wr_ptr_q] = mdu_pc;
            wr_ptr_d           = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // The starve counter tracks how long a non-empty FIFO has been
        // denied the port. It saturates so a forced drain stays pending.
        if (!fifo_nonempty || grant_fifo) begin
            starve_d = '0;
        end else if (starve_q != MAX_WAIT_C) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // busy_mask is built from registered entries only. Queued entries never
    // target $0, so bit 0 always stays clear.
    always_comb begin
        busy_mask = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count_q) begin
                busy_mask[mem_a3_q[PTR_W'(rd_ptr_q + PTR_W'(i))]] = 1'b1;
            end
        end
    end

    // Control state register. Reset empties the queue and drops any entries
    // that were pending.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end

    // Entry storage. It needs no reset, because only slots counted by
    // count_q are ever read.
    always_ff @(posedge clk) begin
        mem_a3_q <= mem_a3_d;
        mem_wd_q <= mem_wd_d;
        mem_pc_q <= mem_pc_d;
    end

endmodule

// File: doc/grf_wport_arbiter.md
Name: grf_wport_arbiter

Overview:
- Shares the single GRF write port between the W-stage writeback and the multi-cycle multiply/divide unit (MDU) result path.
- MDU results are buffered in a small FIFO and drained into the GRF on cycles the W stage does not write.
- A starvation counter can force a drain, in which case the W stage is stalled.
- Publishes a busy mask of registers with queued writes, which decode uses for hazard stalls.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
MAX_WAIT, 3, consecutive starved cycles before a forced FIFO drain; at least 1.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-low; reset==0 at posedge clears all state.
pipe_we  in  1  W-stage write request.
pipe_a3  in  5  W-stage destination register.
pipe_wd  in  32  W-stage write data.
pipe_pc  in  32  W-stage PC, forwarded for the GRF write log.
pipe_stall  out  1  W-stage write was not performed this cycle; W must hold and retry.
mdu_valid  in  1  MDU result offered.
mdu_a3  in  5  MDU destination register.
mdu_wd  in  32  MDU result data.
mdu_pc  in  32  PC of the MDU instruction.
mdu_ready  out  1  FIFO can accept a result.
grf_we  out  1  GRF write enable.
grf_a3  out  5  GRF write address.
grf_wd  out  32  GRF write data.
grf_pc  out  32  PC presented to the GRF.
busy_mask  out  32  bit r=1 while any queued FIFO entry targets register r.

Behaviour:
- Reset (reset==0 at posedge):
  - FIFO emptied: read/write pointers=0, count=0.
  - Starve counter=0.
- Combinational overrides while reset==0:
  - grf_we=0, pipe_stall=0, mdu_ready=0.
  - busy_mask reflects state, so it is 0 after the first reset edge.
- pipe_valid = pipe_we && pipe_a3!=0. A write to $0 counts as no request.
- FIFO:
  - Circular buffer of {a3, wd, pc}.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - count is 0..DEPTH.
- mdu_ready = (count<DEPTH) && reset.
- Push when mdu_valid && mdu_ready && mdu_a3!=0. If mdu_a3==0 with mdu_valid && mdu_ready, the result is accepted and discarded.
- No bypass: an entry pushed at edge N is eligible for the GRF no earlier than the cycle after edge N.
- When full, mdu_ready=0 even if a pop occurs in the same cycle. Push and pop in the same cycle are permitted when not full.
- Grant, combinational each cycle:
  - force = (count!=0) && (starve==MAX_WAIT).
  - If force: grant the FIFO head. pipe_stall = pipe_valid.
  - Else if pipe_valid: grant the pipeline. pipe_stall=0.
  - Else if count!=0: grant the FIFO head.
  - Else: grf_we=0.
- GRF outputs:
  - grf_* carry the granted source's a3/wd/pc with grf_we=1.
  - When no source is granted: grf_a3=0, grf_wd=0, grf_pc=0.
- FIFO grant pops the head at the next posedge.
- Starve counter:
  - Cleared when count==0 or the FIFO is granted.
  - Otherwise increments, saturating at MAX_WAIT.
- busy_mask: OR over valid entries of a one-hot encoding of the entry's a3. Computed from registered state, so it changes only at edges.
- Ordering:
  - FIFO entries retire in arrival order.
  - Ordering between pipeline writes and FIFO writes is not enforced here. Decode must stall any instruction whose destination or sources hit busy_mask.
- Reset mid-operation discards queued entries without writing them.

Test Plan:
1. Release reset, idle inputs -> grf_we=0, busy_mask=0, mdu_ready=1, pipe_stall=0.
2. pipe_we=1, a3=5, wd=0x1234 with FIFO empty -> same cycle grf_we=1, grf_a3=5, grf_wd=0x1234, pipe_stall=0. With a3=0 instead -> grf_we=0.
3. Push MDU a3=8, wd=0xAA while the pipeline is idle:
   - Next cycle: busy_mask=0x100, grf_we=1, grf_a3=8.
   - Following cycle: busy_mask=0.
4. Push 4 MDU results with the pipeline writing every cycle:
   - After the 4th push: mdu_ready=0.
   - After MAX_WAIT=3 starved cycles: the head is written, pipe_stall=1 for that one cycle, then the counter restarts.
5. FIFO holds 2 entries; pipeline idle while a push arrives on the same cycle as a pop -> count stays 2, entries retire in push order.
6. Queue 3 entries, assert reset=0 for one edge -> all queued writes lost, busy_mask=0, grf_we=0 during the reset cycle, mdu_ready=1 after release.
